// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update scheduler.
package bp_pkg;

    localparam int unsigned PC_WIDTH     = 32;
    localparam int unsigned GSHARE_WIDTH = 8;
    localparam int unsigned PHT_LEN      = 1 << GSHARE_WIDTH;

    localparam logic [1:0] PHT_WEAK_TAKEN = 2'b10;

    typedef enum logic {
        BPS_INIT = 1'b0,
        BPS_RUN  = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                taken;
    } bp_upd_entry_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// In-order update queue: up to two writes (older slot first) and one read per cycle.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_first_en,
    input  bp_upd_entry_t             wr_first,
    input  logic                      wr_second_en,
    input  bp_upd_entry_t             wr_second,
    input  logic                      rd_en,
    output bp_upd_entry_t             rd_head,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    free_slots
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    bp_upd_entry_t  mem_q [DEPTH];
    bp_upd_entry_t  mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     n_push;
    logic [PW-1:0]  wr_ptr_nx;
    logic [PW-1:0]  second_idx;

    always_comb begin
        n_push     = {1'b0, wr_first_en} + {1'b0, wr_second_en};
        wr_ptr_nx  = wr_ptr_q + PW'(1);
        // A lone younger update takes the next free entry, leaving no hole.
        second_idx = wr_first_en ? wr_ptr_nx : wr_ptr_q;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_first_en) begin
                mem_d[wr_ptr_q] = wr_first;
            end
            if (wr_second_en) begin
                mem_d[second_idx] = wr_second;
            end
            wr_ptr_d = wr_ptr_q + PW'(n_push);
            rd_ptr_d = rd_en ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
            count_d  = count_q + CW'(n_push) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_head    = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign free_slots = CW'(DEPTH) - count_q;

endmodule

// File: rtl/bp_update_sched.sv
// Serialises dual resolved-branch updates onto one predictor port and sequences PHT init sweeps.
//   state    | meaning
//   BPS_INIT | sweeping init_idx over every PHT entry, inputs blocked
//   BPS_RUN  | accepting updates into the queue and draining one per cycle
module bp_update_sched #(
    parameter int unsigned GSHARE_WIDTH = bp_pkg::GSHARE_WIDTH,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid_first,
    input  logic [bp_pkg::PC_WIDTH-1:0]   in_pc_first,
    input  logic                          in_taken_first,
    input  logic                          in_valid_second,
    input  logic [bp_pkg::PC_WIDTH-1:0]   in_pc_second,
    input  logic                          in_taken_second,
    output logic                          in_ready,
    input  logic                          init_req,
    output logic                          upd_valid,
    output logic [bp_pkg::PC_WIDTH-1:0]   upd_pc,
    output logic                          upd_taken,
    output logic                          init_valid,
    output logic [GSHARE_WIDTH-1:0]       init_idx,
    output logic                          busy
);

    import bp_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bp_state_t               state_q, state_d;
    logic [GSHARE_WIDTH-1:0] init_idx_q, init_idx_d;

    logic          push_first, push_second, fifo_flush, fifo_pop;
    bp_upd_entry_t entry_first, entry_second, head;
    logic [CW-1:0] fifo_count, free_slots;

    assign entry_first  = '{pc: in_pc_first,  taken: in_taken_first};
    assign entry_second = '{pc: in_pc_second, taken: in_taken_second};

    bp_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .flush        (fifo_flush),
        .wr_first_en  (push_first),
        .wr_first     (entry_first),
        .wr_second_en (push_second),
        .wr_second    (entry_second),
        .rd_en        (fifo_pop),
        .rd_head      (head),
        .count        (fifo_count),
        .free_slots   (free_slots)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BPS_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            BPS_INIT: begin
                if (init_req) begin
                    init_idx_d = '0;
                end else if (&init_idx_q) begin
                    state_d    = BPS_RUN;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + GSHARE_WIDTH'(1);
                end
            end
            BPS_RUN: begin
                if (init_req) begin
                    state_d    = BPS_INIT;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d    = BPS_INIT;
                init_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        init_valid  = (state_q == BPS_INIT);
        in_ready    = (state_q == BPS_RUN) && (free_slots >= CW'(2));
        upd_valid   = (state_q == BPS_RUN) && (fifo_count != '0);
        upd_pc      = upd_valid ? head.pc : '0;
        upd_taken   = upd_valid & head.taken;
        busy        = (state_q == BPS_INIT) || (fifo_count != '0);
        // The head presented during a flush cycle still counts as delivered.
        fifo_pop    = upd_valid;
        fifo_flush  = (state_q == BPS_RUN) && init_req;
        push_first  = in_ready && in_valid_first  && !init_req;
        push_second = in_ready && in_valid_second && !init_req;
    end

    assign init_idx = init_idx_q;

endmodule
